// File: rtl/mem_req_arbiter.sv
// Memory request arbiter: one of NUM_CH requesters gets the memory port; line-fill
// reads become aligned BURST_LEN-beat bursts. Define ARB_ROUND_ROBIN_EN for rotating grant.

module mem_req_arbiter_chk #(
    parameter int unsigned NUM_CH = 2
) (
    input logic              aclk,
    input logic              aresetn,
    input logic              mem_access,
    input logic              ch_last,
    input logic [NUM_CH-1:0] ch_ready
);

    a_ready_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
        $onehot0(ch_ready));

    a_ready_needs_access: assert property (@(posedge aclk) disable iff (!aresetn)
        (ch_ready != '0) |-> mem_access);

    a_last_with_ready: assert property (@(posedge aclk) disable iff (!aresetn)
        ch_last |-> (ch_ready != '0));

endmodule

module mem_req_arbiter #(
    parameter int unsigned       NUM_CH     = 2,
    parameter int unsigned       BURST_LEN  = 4,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = 2'b10
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 flush,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH-1:0]    ch_write,
    input  logic [NUM_CH-1:0]    ch_burst,
    input  logic [NUM_CH*32-1:0] ch_addr,
    input  logic [NUM_CH*2-1:0]  ch_size,
    input  logic [NUM_CH*4-1:0]  ch_sel,
    input  logic [NUM_CH*32-1:0] ch_wdata,
    output logic [NUM_CH-1:0]    ch_ready,
    output logic                 ch_last,
    output logic [31:0]          ch_rdata,
    output logic [31:0]          mem_a,
    output logic                 mem_access,
    output logic                 mem_write,
    output logic [1:0]           mem_size,
    output logic [3:0]           mem_sel,
    output logic [31:0]          mem_st_data,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_data
);

    localparam int unsigned    CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned    BW         = $clog2(BURST_LEN) + 1;
    localparam logic [31:0]    ALIGN_MASK = 32'(BURST_LEN * 4 - 1);
    localparam logic [BW-1:0]  LAST_BEAT  = BW'(BURST_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [31:0]     addr_q, addr_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            burst_q, burst_d;
    logic [BW-1:0]   beat_q, beat_d;

    logic            gnt_valid_s;
    logic [CW-1:0]   gnt_idx_s;
    logic [31:0]     cand_addr_s;
    logic [31:0]     cand_wdata_s;
    logic [1:0]      cand_size_s;
    logic [3:0]      cand_sel_s;
    logic            cand_write_s;
    logic            cand_burst_s;
    logic            busy_s;
    logic            flush_hit_s;
    logic            last_beat_s;
    logic            beat_done_s;
    logic [NUM_CH-1:0] ch_ready_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW:0]         ptr_inc_s;
    logic [CW:0]         off_s;
    logic [CW:0]         sum_s;
    logic [2*NUM_CH-1:0] rot_s;

    // Rotating grant: rotate requests so the channel after the pointer sits at bit 0.
    always_comb begin
        gnt_valid_s = |ch_req;
        ptr_inc_s   = {1'b0, rr_ptr_q} + {{CW{1'b0}}, 1'b1};
        rot_s       = {ch_req, ch_req} >> ptr_inc_s;
        off_s       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? (CW+1)'(i) : off_s;
        end
        sum_s       = ptr_inc_s + off_s;
        gnt_idx_s   = (sum_s >= (CW+1)'(NUM_CH)) ? CW'(sum_s - (CW+1)'(NUM_CH)) : CW'(sum_s);
    end
`else
    // Fixed-priority grant: the lowest requesting index wins.
    always_comb begin
        gnt_valid_s = |ch_req;
        gnt_idx_s   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            gnt_idx_s = ch_req[i] ? CW'(i) : gnt_idx_s;
        end
    end
`endif

    // Request fields of the channel that would win this cycle.
    always_comb begin
        cand_addr_s  = ch_addr[{gnt_idx_s, 5'b00000} +: 32];
        cand_wdata_s = ch_wdata[{gnt_idx_s, 5'b00000} +: 32];
        cand_size_s  = ch_size[{gnt_idx_s, 1'b0} +: 2];
        cand_sel_s   = ch_sel[{gnt_idx_s, 2'b00} +: 4];
        cand_write_s = ch_write[gnt_idx_s];
        cand_burst_s = ch_burst[gnt_idx_s] & ~ch_write[gnt_idx_s];
    end

    // Beat status of the transaction in flight; a flush of a maskable channel swallows the beat.
    always_comb begin
        busy_s      = (state_q == ST_BUSY);
        flush_hit_s = busy_s & flush & FLUSH_MASK[grant_q];
        last_beat_s = ~burst_q | (beat_q == LAST_BEAT);
        beat_done_s = busy_s & mem_ready & ~flush_hit_s;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ready_s[i] = beat_done_s & (grant_q == CW'(i));
        end
    end

    // Next-state logic: grant and latch in IDLE, step through beats in BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        burst_d = burst_q;
        beat_d  = beat_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_d = ST_BUSY;
                    grant_d = gnt_idx_s;
                    write_d = cand_write_s;
                    wdata_d = cand_wdata_s;
                    burst_d = cand_burst_s;
                    beat_d  = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_d = gnt_idx_s;
`endif
                    if (cand_burst_s) begin
                        // Line fills always start at the line boundary as full words.
                        addr_d = cand_addr_s & ~ALIGN_MASK;
                        size_d = 2'b10;
                        sel_d  = 4'hF;
                    end else begin
                        addr_d = cand_addr_s;
                        size_d = cand_size_s;
                        sel_d  = cand_sel_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush_hit_s) begin
                    state_d = ST_IDLE;
                end else if (mem_ready) begin
                    if (last_beat_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                        addr_d = addr_q + 32'd4;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            addr_q  <= 32'h0000_0000;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            sel_q   <= 4'h0;
            wdata_q <= 32'h0000_0000;
            burst_q <= 1'b0;
            beat_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q <= CW'(NUM_CH - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign mem_access  = busy_s;
    assign mem_a       = addr_q;
    assign mem_write   = write_q;
    assign mem_size    = size_q;
    assign mem_sel     = sel_q;
    assign mem_st_data = wdata_q;
    assign ch_ready    = ch_ready_s;
    assign ch_last     = beat_done_s & last_beat_s;
    assign ch_rdata    = mem_data;

`ifndef SYNTHESIS
    mem_req_arbiter_chk #(
        .NUM_CH (NUM_CH)
    ) u_chk (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .mem_access (mem_access),
        .ch_last    (ch_last),
        .ch_ready   (ch_ready)
    );
`endif

endmodule
